seven_segment_mux: RTL

//  Multi-digit, time-multiplexed hex seven-segment display driver. Latches a NUM_DIGITS-nibble value

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_hex_encode.sv | 19 +
 rtl/seven_segment_mux.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment types, bit order and hex encode table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg7_t SEG7_ALL_OFF_AL = 7'h7F;

    // Active-low patterns, entry 15 first so that index n selects hex digit n.
    localparam logic [15:0][6:0] SEG7_HEX_AL = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg7_t seg7_encode_al(input logic [3:0] nibble);
        return SEG7_HEX_AL[nibble];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_encode.sv
// ============================================================================
// Module      : seg7_hex_encode
// Description : Combinational 4-bit hex to 7-bit active-low segment encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_encode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_al_o
);

    assign seg_al_o = seg7_encode_al(nibble_i);

endmodule

`default_nettype wire

// File: rtl/seven_segment_mux.sv
// ============================================================================
// Module      : seven_segment_mux
// Description : Time-multiplexed hex seven-segment driver, double-buffered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG7_ALL_OFF_AL : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    w_tick;
    logic                    w_wrap;

    logic [4*NUM_DIGITS-1:0] pend_data_q, disp_data_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q, disp_blank_q;
    logic                    pend_valid_q;

    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    seg7_t                   w_seg_al;
    logic                    w_dark;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q;

    always_comb begin
        w_tick = en && (cnt_q == CNT_LAST);
        w_wrap = w_tick && (idx_q == IDX_LAST);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (en) begin
            cnt_d = w_tick ? '0 : cnt_q + CW'(1);
        end
        if (w_tick) begin
            idx_d = w_wrap ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_an_sel    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                w_nibble    = disp_data_q[4*i +: 4];
                w_dp_sel    = disp_dp_q[i];
                w_blank_sel = disp_blank_q[i];
                w_an_sel[i] = 1'b1;
            end
        end
    end

    seg7_hex_encode u_encode (
        .nibble_i (w_nibble),
        .seg_al_o (w_seg_al)
    );

    // A blanked digit also drops its anode so no ghosting appears on that slot.
    always_comb begin
        w_dark = !en || w_blank_sel;
        seg_d  = w_dark ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? w_seg_al : ~w_seg_al);
        dp_n_d = (w_dark || !w_dp_sel) ? DP_OFF : ~DP_OFF;
        an_d   = w_dark ? AN_OFF : ((AN_ACTIVE_LOW != 0) ? ~w_an_sel : w_an_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            seg_q        <= SEG_OFF;
            dp_n_q       <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            an_q         <= an_d;
            frame_done_q <= w_wrap;

            // Commit only at frame start; a load on the wrap edge waits for the next frame.
            if (w_wrap && pend_valid_q) begin
                disp_data_q  <= pend_data_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
            end
            if (load) begin
                pend_data_q  <= data;
                pend_dp_q    <= dp;
                pend_blank_q <= blank;
                pend_valid_q <= 1'b1;
            end else if (w_wrap) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire
